// File: rtl/dram_stream_reader_pkg.sv
// dram_stream_reader_pkg: shared widths, cache geometry and FSM encoding.
package dram_stream_reader_pkg;
    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 64;
    localparam int FILL_LAT_DEF = 4;
    localparam int CACHE_SLOTS  = 8;
    localparam int SLOT_W       = 3;
    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;
endpackage

// File: rtl/dram_stream_reader_fill_tracker.sv
// fill_tracker: delays each prefetch by the memory fill latency, then marks its cache slot ready.
module fill_tracker
    import dram_stream_reader_pkg::*;
#(
    parameter int FILL_LAT = FILL_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [SLOT_W-1:0]      push_slot,
    input  logic                   clr,
    input  logic [SLOT_W-1:0]      clr_slot,
    input  logic                   flush,
    output logic [CACHE_SLOTS-1:0] rdy
);
    logic [FILL_LAT-1:0][SLOT_W:0] line;
    logic [SLOT_W:0]               tail;
    logic [CACHE_SLOTS-1:0]        set_mask, clr_mask;

    assign tail     = line[FILL_LAT-1];
    assign set_mask = tail[SLOT_W] ? CACHE_SLOTS'(1) << tail[SLOT_W-1:0] : '0;
    assign clr_mask = clr ? CACHE_SLOTS'(1) << clr_slot : '0;

    // A fill landing on the same edge as a consume of that slot keeps the slot ready.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            line <= '0;
            rdy  <= '0;
        end else if (flush) begin
            line <= '0;
            rdy  <= '0;
        end else begin
            line[0] <= {push, push_slot};
            for (int j = 1; j < FILL_LAT; j++) line[j] <= line[j-1];
            rdy <= (rdy & ~clr_mask) | set_mask;
        end
endmodule

// File: rtl/dram_stream_reader.sv
// dram_stream_reader: primes the 8-slot fake_dram cache for a command and streams words
// out in address order, refilling each slot as it is consumed.
module dram_stream_reader
    import dram_stream_reader_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FILL_LAT = FILL_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_start,
    input  logic [DATA_W-1:0] mem_dout
);
    state_t                 state;
    logic [ADDR_W-1:0]      base;
    logic [ADDR_W:0]        len, i, prime_n;
    logic [SLOT_W-1:0]      k;
    logic                   start_r, fire, refill, prime_last;
    logic [CACHE_SLOTS-1:0] rdy;

    assign cmd_ready  = state == IDLE;
    assign out_valid  = state == STREAM && rdy[mem_addr[SLOT_W-1:0]];
    assign out_data   = mem_dout;
    assign out_last   = out_valid && i == len - (ADDR_W+1)'(1);
    assign fire       = out_valid && out_ready;
    assign prime_n    = len > (ADDR_W+1)'(CACHE_SLOTS) ? (ADDR_W+1)'(CACHE_SLOTS) : len;
    assign prime_last = (ADDR_W+1)'(k) == prime_n - (ADDR_W+1)'(1);
    // Consuming word i frees its slot for word i+8, if the command still needs it.
    assign refill     = fire && ({1'b0, i} + (ADDR_W+2)'(CACHE_SLOTS) < {1'b0, len});
    assign mem_start  = start_r || refill;
    assign mem_we     = 1'b0;
    assign mem_din    = '0;

    fill_tracker #(.FILL_LAT(FILL_LAT)) u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_start),
        .push_slot (mem_addr[SLOT_W-1:0]),
        .clr       (fire),
        .clr_slot  (mem_addr[SLOT_W-1:0]),
        .flush     (cmd_valid && cmd_ready),
        .rdy       (rdy)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            len      <= '0;
            i        <= '0;
            k        <= '0;
            mem_addr <= '0;
            start_r  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    base <= cmd_base;
                    len  <= cmd_len;
                    if (cmd_len == '0) done <= 1'b1;
                    else begin
                        state    <= PRIME;
                        k        <= '0;
                        mem_addr <= cmd_base - ADDR_W'(CACHE_SLOTS);
                        start_r  <= 1'b1;
                    end
                end
                PRIME: if (prime_last) begin
                    state    <= STREAM;
                    mem_addr <= base;
                    start_r  <= 1'b0;
                    i        <= '0;
                end else begin
                    k        <= k + SLOT_W'(1);
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                STREAM: if (fire) begin
                    i        <= i + (ADDR_W+1)'(1);
                    mem_addr <= mem_addr + ADDR_W'(1);
                    if (out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_dram_stream_reader.sv
// tb_dram_stream_reader: directed commands against a fake_dram cache model with a
// scoreboard of expected words (mem[a] = a*3).
module tb_dram_stream_reader;
    logic        clk = 0, rst_n = 0;
    logic        cmd_valid = 0, cmd_ready;
    logic [9:0]  cmd_base = 0;
    logic [10:0] cmd_len = 0;
    logic        out_valid, out_ready = 1, out_last, done, mem_we, mem_start;
    logic [63:0] out_data, mem_din, mem_dout;
    logic [9:0]  mem_addr;
    logic        rnd = 0;
    int          compared = 0, mismatched = 0;
    int          starts = 0, fired = 0, done_cnt = 0;
    logic [63:0] sb[$];
    logic [9:0]  saddr[$];
    logic        exp_done = 0, prev_stall = 0;
    logic [63:0] prev_data = 0;
    logic [63:0] mem[1024];
    logic [63:0] cache[8];
    logic        p_v[4];
    logic [9:0]  p_a[4];

    always #5 clk = ~clk;

    dram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_start (mem_start),
        .mem_dout  (mem_dout)
    );

    // fake_dram: a start sampled at one edge fills slot addr[2:0] with mem[addr+8] four edges later
    assign mem_dout = cache[mem_addr[2:0]];
    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 64'(a) * 64'd3;
        for (int j = 0; j < 8; j++) cache[j] = 64'hBAD0_0000 + 64'(j);
        for (int j = 0; j < 4; j++) begin
            p_v[j] = 0;
            p_a[j] = 0;
        end
    end
    always @(posedge clk) begin
        p_v[0] <= mem_start;
        p_a[0] <= mem_addr;
        for (int j = 1; j < 4; j++) begin
            p_v[j] <= p_v[j-1];
            p_a[j] <= p_a[j-1];
        end
        if (p_v[3]) cache[p_a[3][2:0]] <= mem[p_a[3] + 10'd8];
    end

    initial forever begin
        @(posedge clk);
        #1 out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done   = 0;
            prev_stall = 0;
        end else begin
            check("done", 64'(done), 64'(exp_done));
            if (done) done_cnt++;
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", out_data, prev_data);
            end
            if (mem_start) begin
                starts++;
                saddr.push_back(mem_addr);
            end
            if (out_valid && !out_ready) check("stall_start", 64'(mem_start), 64'(0));
            if (out_valid && out_ready) begin
                fired++;
                if (sb.size() == 0) check("extra_word", 64'(sb.size()), 64'(1));
                else begin
                    check("data", out_data, sb[0]);
                    check("last", 64'(out_last), 64'(sb.size() == 1));
                    void'(sb.pop_front());
                end
            end
            exp_done   = (out_valid && out_ready && out_last) || (cmd_valid && cmd_ready && cmd_len == 0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send(input logic [9:0] b, input logic [10:0] n);
        @(posedge clk);
        #1;
        cmd_valid = 1;
        cmd_base  = b;
        cmd_len   = n;
        for (int m = 0; m < int'(n); m++) sb.push_back(64'(10'(b + 10'(m))) * 64'd3);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 1000 && done_cnt == d0; c++) @(negedge clk);
        check("done_seen", 64'(done_cnt - d0), 64'(1));
    endtask

    initial begin
        int s0, d0, f0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_start", 64'(mem_start), 64'(0));
        check("mem_we", 64'(mem_we), 64'(0));
        check("mem_din", mem_din, 64'(0));
        @(posedge clk);
        #1 rst_n = 1;

        // base 16, len 20, with a command attempt while busy
        s0 = starts;
        d0 = done_cnt;
        send(10'd16, 11'd20);
        repeat (12) @(posedge clk);
        #1;
        cmd_valid = 1;
        cmd_base  = 10'd500;
        cmd_len   = 11'd5;
        repeat (3) begin
            @(negedge clk);
            check("busy_cmd_ready", 64'(cmd_ready), 64'(0));
        end
        @(posedge clk);
        #1 cmd_valid = 0;
        wait_done(d0);
        check("starts_16x20", 64'(starts - s0), 64'(20));
        check("sb_empty_16x20", 64'(sb.size()), 64'(0));

        // short command: primes only
        saddr.delete();
        s0 = starts;
        d0 = done_cnt;
        send(10'd100, 11'd3);
        wait_done(d0);
        check("starts_100x3", 64'(starts - s0), 64'(3));
        check("prime_addr0", 64'(saddr[0]), 64'(92));
        check("prime_addr1", 64'(saddr[1]), 64'(93));
        check("prime_addr2", 64'(saddr[2]), 64'(94));
        check("sb_empty_100x3", 64'(sb.size()), 64'(0));

        // wrap-around under random backpressure
        rnd = 1;
        s0 = starts;
        d0 = done_cnt;
        send(10'd1020, 11'd10);
        wait_done(d0);
        rnd = 0;
        check("starts_wrap", 64'(starts - s0), 64'(10));
        check("sb_empty_wrap", 64'(sb.size()), 64'(0));

        // zero-length command
        s0 = starts;
        d0 = done_cnt;
        send(10'd5, 11'd0);
        wait_done(d0);
        repeat (3) begin
            @(negedge clk);
            check("len0_cmd_ready", 64'(cmd_ready), 64'(1));
        end
        check("starts_len0", 64'(starts - s0), 64'(0));

        // reset during a long stream, then a fresh command
        f0 = fired;
        send(10'd0, 11'd64);
        for (int c = 0; c < 200 && fired - f0 < 10; c++) @(negedge clk);
        check("pre_reset_words", 64'(fired - f0 >= 10), 64'(1));
        @(posedge clk);
        #1 rst_n = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("post_rst_mem_start", 64'(mem_start), 64'(0));
        s0 = starts;
        d0 = done_cnt;
        send(10'd200, 11'd8);
        wait_done(d0);
        check("starts_200x8", 64'(starts - s0), 64'(8));
        check("sb_empty_200x8", 64'(sb.size()), 64'(0));
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
